// File: rtl/alu_mcycle_sequencer.sv
// alu_mcycle_sequencer: borrows the shared ALU for unsigned shift-add multiply and restoring divide.
// One ALU operation per cycle; WIDTH iterations per operation.
module alu_mcycle_sequencer #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 5
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             Start,
    input  logic             MCycleOp,
    input  logic [WIDTH-1:0] Operand1,
    input  logic [WIDTH-1:0] Operand2,
    input  logic [WIDTH-1:0] ALU_Result,
    input  logic [3:0]       ALU_Flags,
    output logic [WIDTH-1:0] ALU_SrcA,
    output logic [WIDTH-1:0] ALU_SrcB,
    output logic [1:0]       ALU_Control,
    output logic             AluSel,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Result1,
    output logic [WIDTH-1:0] Result2
);
    typedef enum logic [1:0] {IDLE, COMPUTE, DONE} state_t;

    state_t           state_q;
    logic [CNT_W-1:0] count_q;
    logic             op_q;
    logic [WIDTH-1:0] hi_q, lo_q, mc_q;
    logic [WIDTH-1:0] hi_d, lo_d, sh;
    logic             take, carry;
    logic             unused_flags;

    assign carry        = ALU_Flags[1];
    assign unused_flags = ^{ALU_Flags[3:2], ALU_Flags[0]};
    // hi_q/lo_q hold {hi,lo} for multiply and {rem,quo} for divide; mc_q holds multiplicand or divisor
    assign sh          = {hi_q[WIDTH-2:0], lo_q[WIDTH-1]};
    assign take        = hi_q[WIDTH-1] | carry;
    assign ALU_SrcA    = op_q ? sh : hi_q;
    assign ALU_SrcB    = (op_q || lo_q[0]) ? mc_q : '0;
    assign ALU_Control = {1'b0, op_q};

    always_comb begin
        hi_d = op_q ? (take ? ALU_Result : sh) : {carry, ALU_Result[WIDTH-1:1]};
        lo_d = op_q ? {lo_q[WIDTH-2:0], take} : {ALU_Result[0], lo_q[WIDTH-1:1]};
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= IDLE;
            count_q <= '0;
            op_q    <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            mc_q    <= '0;
            AluSel  <= 1'b0;
            Busy    <= 1'b0;
            Done    <= 1'b0;
            Result1 <= '0;
            Result2 <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    Done <= 1'b0;
                    if (Start) begin
                        op_q    <= MCycleOp;
                        count_q <= '0;
                        if (MCycleOp && Operand2 == '0) begin
                            state_q <= DONE;
                            Done    <= 1'b1;
                            Result1 <= '1;
                            Result2 <= Operand1;
                        end else begin
                            state_q <= COMPUTE;
                            hi_q    <= '0;
                            lo_q    <= MCycleOp ? Operand1 : Operand2;
                            mc_q    <= MCycleOp ? Operand2 : Operand1;
                            Busy    <= 1'b1;
                            AluSel  <= 1'b1;
                        end
                    end
                end
                COMPUTE: begin
                    hi_q    <= hi_d;
                    lo_q    <= lo_d;
                    count_q <= count_q + 1'b1;
                    if (count_q == CNT_W'(WIDTH - 1)) begin
                        state_q <= DONE;
                        Busy    <= 1'b0;
                        AluSel  <= 1'b0;
                        Done    <= 1'b1;
                        Result1 <= lo_d;
                        Result2 <= hi_d;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    Done    <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_alu_mcycle_sequencer.sv
// tb_alu_mcycle_sequencer: drives directed and random multiply/divide jobs through the sequencer
// with a behavioural ALU attached, checking timing and results against plain arithmetic.
module tb_alu_mcycle_sequencer;
    logic        CLK = 1'b0;
    logic        RESET, Start, MCycleOp;
    logic [31:0] Operand1, Operand2, ALU_Result, ALU_SrcA, ALU_SrcB, Result1, Result2;
    logic [3:0]  ALU_Flags;
    logic [1:0]  ALU_Control;
    logic        AluSel, Busy, Done;
    logic [32:0] alu_wide;
    int          n_assert = 0;
    int          n_fail   = 0;

    alu_mcycle_sequencer dut (
        .CLK(CLK), .RESET(RESET), .Start(Start), .MCycleOp(MCycleOp),
        .Operand1(Operand1), .Operand2(Operand2), .ALU_Result(ALU_Result), .ALU_Flags(ALU_Flags),
        .ALU_SrcA(ALU_SrcA), .ALU_SrcB(ALU_SrcB), .ALU_Control(ALU_Control), .AluSel(AluSel),
        .Busy(Busy), .Done(Done), .Result1(Result1), .Result2(Result2)
    );

    always #5 CLK = ~CLK;

    // Shared ALU: add gives carry-out, subtract gives C=1 when no borrow
    assign alu_wide   = ALU_Control[0] ? ({1'b0, ALU_SrcA} + {1'b0, ~ALU_SrcB} + 33'd1)
                                       : ({1'b0, ALU_SrcA} + {1'b0, ALU_SrcB});
    assign ALU_Result = alu_wide[31:0];
    assign ALU_Flags  = {alu_wide[31], alu_wide[31:0] == 32'd0, alu_wide[32], 1'b0};

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic model(input logic op, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] r1, output logic [31:0] r2);
        longint unsigned p;
        if (!op) begin
            p  = longint'(a) * longint'(b);
            r1 = p[31:0];
            r2 = p[63:32];
        end else if (b == 0) begin
            r1 = 32'hFFFF_FFFF;
            r2 = a;
        end else begin
            r1 = a / b;
            r2 = a % b;
        end
    endtask

    task automatic run_op(input logic op, input logic [31:0] a, input logic [31:0] b, input int restart_at);
        int          cyc, busy_n, sel_n;
        logic [31:0] e1, e2;
        model(op, a, b, e1, e2);
        Start = 1'b1; MCycleOp = op; Operand1 = a; Operand2 = b;
        step();
        Start = 1'b0; MCycleOp = ~op; Operand1 = $urandom; Operand2 = $urandom;
        cyc = 1; busy_n = 0; sel_n = 0;
        while (!Done && cyc < 40) begin
            if (Busy) busy_n++;
            if (AluSel) sel_n++;
            if (cyc == 1 && Busy) chk("alu_ctrl", 32'(ALU_Control), {31'd0, op});
            if (cyc == restart_at) begin
                Start = 1'b1; MCycleOp = ~op;
            end
            step();
            Start = 1'b0;
            cyc++;
        end
        chk("done_cycle", cyc, (op && b == 0) ? 1 : 33);
        chk("busy_cycles", busy_n, (op && b == 0) ? 0 : 32);
        chk("alusel_cycles", sel_n, (op && b == 0) ? 0 : 32);
        chk("result1", Result1, e1);
        chk("result2", Result2, e2);
        step();
        chk("done_pulse_end", {31'd0, Done}, 0);
        chk("busy_after", {31'd0, Busy}, 0);
        step();
        chk("result1_hold", Result1, e1);
        chk("result2_hold", Result2, e2);
    endtask

    initial begin
        int dn;
        RESET = 1'b1; Start = 1'b0; MCycleOp = 1'b0; Operand1 = '0; Operand2 = '0;
        step(); step();
        RESET = 1'b0;
        chk("rst_busy", {31'd0, Busy}, 0);
        chk("rst_done", {31'd0, Done}, 0);
        chk("rst_alusel", {31'd0, AluSel}, 0);
        chk("rst_r1", Result1, 0);
        chk("rst_r2", Result2, 0);
        chk("rst_srca", ALU_SrcA, 0);
        chk("rst_srcb", ALU_SrcB, 0);
        chk("rst_ctrl", 32'(ALU_Control), 0);
        step();
        chk("idle_busy", {31'd0, Busy}, 0);

        run_op(1'b0, 32'd7, 32'd6, 0);
        chk("mul7x6_r1", Result1, 32'h2A);
        run_op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        chk("mul_max_r2", Result2, 32'hFFFF_FFFE);
        run_op(1'b1, 32'd100, 32'd7, 0);
        chk("div100_7_q", Result1, 32'd14);
        run_op(1'b1, 32'hFFFF_FFFF, 32'h8000_0001, 0);
        chk("div_msb_r", Result2, 32'h7FFF_FFFE);
        run_op(1'b1, 32'hFFFF_FFFF, 32'd1, 0);
        run_op(1'b1, 32'h1234, 32'd0, 0);
        chk("div0_r2", Result2, 32'h1234);
        run_op(1'b0, 32'h1234_5678, 32'h9ABC_DEF0, 10);
        run_op(1'b1, 32'hDEAD_BEEF, 32'h0000_0013, 33);

        Start = 1'b1; MCycleOp = 1'b1; Operand1 = 32'd1000; Operand2 = 32'd3;
        step();
        Start = 1'b0;
        repeat (14) step();
        chk("pre_rst_busy", {31'd0, Busy}, 1);
        RESET = 1'b1;
        step();
        RESET = 1'b0;
        chk("midrst_busy", {31'd0, Busy}, 0);
        chk("midrst_alusel", {31'd0, AluSel}, 0);
        chk("midrst_r1", Result1, 0);
        chk("midrst_r2", Result2, 0);
        dn = 0;
        for (int i = 0; i < 40; i++) begin
            if (Done) dn++;
            step();
        end
        chk("midrst_no_done", dn, 0);

        RESET = 1'b1; Start = 1'b1; MCycleOp = 1'b0; Operand1 = 32'd3; Operand2 = 32'd5;
        step();
        RESET = 1'b0; Start = 1'b0;
        chk("rst_wins_busy", {31'd0, Busy}, 0);
        step();
        chk("rst_wins_idle", {31'd0, Busy}, 0);

        run_op(1'b0, 32'd3, 32'd5, 0);
        for (int i = 0; i < 16; i++) begin
            logic [31:0] a, b;
            logic        op;
            op = 1'($urandom);
            a  = $urandom;
            b  = $urandom;
            if (i % 4 == 1) b = b >> $urandom_range(31, 20);
            if (i % 7 == 3) b = 32'd0;
            run_op(op, a, b, (i % 3 == 0) ? $urandom_range(32, 2) : 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
